// File: rtl/acq_readout_sequencer.sv
// rtl/acq_readout_sequencer.sv - arms the trigger, waits for data_ready, streams enabled channels' samples as bytes
// Optional feature macro: ACQ_READOUT_HEADER_EN (A5 + channel header bytes before each channel's samples)
module acq_readout_sequencer #(
    parameter int RAM_WIDTH  = 10,
    parameter int RD_LAT     = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 go,
    input  logic                 abort,
    input  logic [3:0]           chan_mask,
    input  logic [RAM_WIDTH-1:0] nsmp,
    input  logic [RAM_WIDTH-1:0] pretrig,
    input  logic [RAM_WIDTH-1:0] trig_addr,
    input  logic                 data_ready,
    output logic                 start_trigger,
    output logic                 rden,
    output logic [RAM_WIDTH-1:0] rdaddress,
    output logic [1:0]           rdchan,
    input  logic [7:0]           rddata,
    output logic [7:0]           tx_data,
    output logic                 tx_valid,
    input  logic                 tx_ready,
    output logic                 busy,
    output logic                 done
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 2;

    typedef enum logic [2:0] {S_IDLE, S_ARM, S_WAITLO, S_WAITHI, S_READ, S_DRAIN} state_t;
    state_t state;

    logic [3:0]           mask_q;
    logic [RAM_WIDTH-1:0] nsmp_m1, pretrig_q, start_q, cnt;
    logic [1:0]           chan;
    logic                 iss_v;
    logic [RD_LAT-1:0]    pipe_v;
    logic [7:0]           fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]        wr_ptr, rd_ptr;
    logic [CW-1:0]        fifo_count, count_after, inflight_after;
    logic                 push, pop, space;
    logic [7:0]           push_data;
    logic [1:0]           first_chan, next_chan;
    logic                 has_next;

`ifdef ACQ_READOUT_HEADER_EN
    logic              iss_h;
    logic [7:0]        iss_b;
    logic [RD_LAT-1:0] pipe_h;
    logic [7:0]        pipe_b [RD_LAT];
    logic [1:0]        hdr_cnt;
    assign push_data = pipe_h[RD_LAT-1] ? pipe_b[RD_LAT-1] : rddata;
`else
    assign push_data = rddata;
`endif

    assign push     = pipe_v[RD_LAT-1];
    assign tx_valid = (fifo_count != '0);
    assign tx_data  = fifo_mem[rd_ptr];
    assign pop      = tx_valid && tx_ready;

    // Credit check uses post-edge occupancy so a steady tx_ready=1 stream issues every cycle.
    always_comb begin
        inflight_after = CW'(iss_v);
        for (int k = 0; k < RD_LAT - 1; k++)
            inflight_after = inflight_after + CW'(pipe_v[k]);
        count_after = fifo_count + CW'(push) - CW'(pop);
        space       = (count_after + inflight_after) < CW'(FIFO_DEPTH);
    end

    always_comb begin
        first_chan = 2'd0;
        next_chan  = 2'd0;
        has_next   = 1'b0;
        for (int i = 3; i >= 0; i--) begin
            if (mask_q[i])
                first_chan = 2'(i);
            if (mask_q[i] && (i > int'(chan))) begin
                next_chan = 2'(i);
                has_next  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pipe_v <= '0;
        end else if (abort) begin
            pipe_v <= '0;
        end else begin
            pipe_v[0] <= iss_v;
            for (int k = 1; k < RD_LAT; k++)
                pipe_v[k] <= pipe_v[k-1];
        end
    end

`ifdef ACQ_READOUT_HEADER_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pipe_h <= '0;
            for (int k = 0; k < RD_LAT; k++)
                pipe_b[k] <= 8'h00;
        end else begin
            pipe_h[0] <= iss_h;
            pipe_b[0] <= iss_b;
            for (int k = 1; k < RD_LAT; k++) begin
                pipe_h[k] <= pipe_h[k-1];
                pipe_b[k] <= pipe_b[k-1];
            end
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (push && !abort)
            fifo_mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else if (abort) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            fifo_count <= count_after;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state         <= S_IDLE;
            start_trigger <= 1'b0;
            rden          <= 1'b0;
            rdaddress     <= '0;
            rdchan        <= 2'd0;
            busy          <= 1'b0;
            done          <= 1'b0;
            iss_v         <= 1'b0;
            mask_q        <= 4'd0;
            nsmp_m1       <= '0;
            pretrig_q     <= '0;
            start_q       <= '0;
            cnt           <= '0;
            chan          <= 2'd0;
`ifdef ACQ_READOUT_HEADER_EN
            iss_h         <= 1'b0;
            iss_b         <= 8'h00;
            hdr_cnt       <= 2'd0;
`endif
        end else begin
            start_trigger <= 1'b0;
            rden          <= 1'b0;
            iss_v         <= 1'b0;
            done          <= 1'b0;
`ifdef ACQ_READOUT_HEADER_EN
            iss_h         <= 1'b0;
`endif
            if (abort) begin
                state <= S_IDLE;
                busy  <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: if (go && (chan_mask != 4'd0)) begin
                        mask_q        <= chan_mask;
                        nsmp_m1       <= nsmp - 1'b1;
                        pretrig_q     <= pretrig;
                        start_trigger <= 1'b1;
                        busy          <= 1'b1;
                        state         <= S_ARM;
                    end
                    S_ARM: state <= S_WAITLO;
                    S_WAITLO: if (!data_ready) state <= S_WAITHI;
                    S_WAITHI: if (data_ready) begin
                        start_q <= trig_addr - pretrig_q;
                        chan    <= first_chan;
                        cnt     <= '0;
`ifdef ACQ_READOUT_HEADER_EN
                        hdr_cnt <= 2'd0;
`endif
                        state   <= S_READ;
                    end
                    S_READ: if (space) begin
`ifdef ACQ_READOUT_HEADER_EN
                        if (hdr_cnt != 2'd2) begin
                            iss_v   <= 1'b1;
                            iss_h   <= 1'b1;
                            iss_b   <= (hdr_cnt == 2'd0) ? 8'hA5 : {6'b0, chan};
                            hdr_cnt <= hdr_cnt + 1'b1;
                        end else
`endif
                        begin
                            rden      <= 1'b1;
                            iss_v     <= 1'b1;
                            rdaddress <= start_q + cnt;
                            rdchan    <= chan;
                            if (cnt == nsmp_m1) begin
                                cnt <= '0;
`ifdef ACQ_READOUT_HEADER_EN
                                hdr_cnt <= 2'd0;
`endif
                                if (has_next)
                                    chan <= next_chan;
                                else
                                    state <= S_DRAIN;
                            end else begin
                                cnt <= cnt + 1'b1;
                            end
                        end
                    end
                    S_DRAIN: if (!iss_v && (pipe_v == '0) &&
                                 ((fifo_count == '0) || ((fifo_count == CW'(1)) && pop))) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_acq_readout_sequencer.sv
// tb/tb_acq_readout_sequencer.sv - scoreboard bench for acq_readout_sequencer
`timescale 1ns/1ps
module tb_acq_readout_sequencer;
    localparam int W  = 10;
    localparam int RL = 2;
    localparam int FD = 4;

    logic         clk = 1'b0, rstn = 1'b0, go = 1'b0, abort = 1'b0, data_ready = 1'b0, tx_ready = 1'b0;
    logic [3:0]   chan_mask = 4'd0;
    logic [W-1:0] nsmp = '0, pretrig = '0, trig_addr = '0;
    logic         start_trigger, rden, tx_valid, busy, done;
    logic [W-1:0] rdaddress;
    logic [1:0]   rdchan;
    logic [7:0]   rddata, tx_data;

    acq_readout_sequencer #(.RAM_WIDTH(W), .RD_LAT(RL), .FIFO_DEPTH(FD)) dut (
        .clk(clk), .rstn(rstn), .go(go), .abort(abort), .chan_mask(chan_mask),
        .nsmp(nsmp), .pretrig(pretrig), .trig_addr(trig_addr), .data_ready(data_ready),
        .start_trigger(start_trigger), .rden(rden), .rdaddress(rdaddress), .rdchan(rdchan),
        .rddata(rddata), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    int st_cnt = 0, done_cnt = 0, issued = 0, accepted = 0;
    int ready_mode = 0, cyc = 0;
    bit chk_en = 1'b1;
    logic [11:0] exp_rd [$];
    logic [7:0]  exp_tx [$];

    function automatic logic [7:0] ram_val(input logic [1:0] c, input logic [W-1:0] a);
        return a[7:0] ^ {c, a[9:8], 4'b0110};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Sample RAM model: RL cycles from rden to rddata
    logic [W+1:0] ram_a [RL];
    always @(posedge clk) begin
        ram_a[0] <= {rdchan, rdaddress};
        for (int k = 1; k < RL; k++)
            ram_a[k] <= ram_a[k-1];
    end
    assign rddata = ram_val(ram_a[RL-1][W+1:W], ram_a[RL-1][W-1:0]);

    initial forever begin
        @(posedge clk);
        #1;
        cyc++;
        case (ready_mode)
            0:       tx_ready = 1'b1;
            1:       tx_ready = (cyc % 3 == 0);
            default: tx_ready = 1'b0;
        endcase
    end

    logic       stalled = 1'b0;
    logic [7:0] held = 8'h00;
    always @(negedge clk) begin
        if (rstn) begin
            if (start_trigger) st_cnt++;
            if (done) done_cnt++;
            if (rden) begin
                issued++;
                if (chk_en) begin
                    if (exp_rd.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL rd_extra: got %0h expected none", {rdchan, rdaddress});
                    end else begin
                        chk("rd_chan_addr", {20'd0, rdchan, rdaddress}, {20'd0, exp_rd.pop_front()});
                    end
                end
            end
            if (tx_valid && stalled)
                chk("tx_stable", {24'd0, tx_data}, {24'd0, held});
            if (tx_valid && tx_ready) begin
                accepted++;
                if (chk_en) begin
                    if (exp_tx.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL tx_extra: got %0h expected none", tx_data);
                    end else begin
                        chk("tx_data", {24'd0, tx_data}, {24'd0, exp_tx.pop_front()});
                    end
                end
            end
            if (chk_en && (rden || tx_valid) && (issued - accepted > FD)) begin
                checks++; errors++;
                $display("FAIL credit: got %0d outstanding expected <= %0d", issued - accepted, FD);
            end
            stalled = tx_valid && !tx_ready;
            held    = tx_data;
        end
    end

    task automatic run(input logic [3:0] m, input int n, input logic [W-1:0] pre,
                       input logic [W-1:0] trig, input bit dup_go);
        int nn;
        int k;
        logic [W-1:0] a;
        nn = (n == 0) ? (1 << W) : n;
        for (int c = 0; c < 4; c++) begin
            if (m[c]) begin
`ifdef ACQ_READOUT_HEADER_EN
                exp_tx.push_back(8'hA5);
                exp_tx.push_back(8'(c));
`endif
                for (int i = 0; i < nn; i++) begin
                    a = trig - pre + W'(i);
                    exp_rd.push_back({2'(c), a});
                    exp_tx.push_back(ram_val(2'(c), a));
                end
            end
        end
        st_cnt = 0; done_cnt = 0; issued = 0; accepted = 0;
        @(posedge clk); #1;
        chan_mask = m; nsmp = W'(n); pretrig = pre; go = 1'b1;
        @(posedge clk); #1;
        go = 1'b0; chan_mask = 4'd0; nsmp = '0; pretrig = '0;
        repeat (3) @(posedge clk);
        #1;
        if (dup_go) begin
            chan_mask = 4'hF; nsmp = W'(3); pretrig = W'(9); go = 1'b1;
            @(posedge clk); #1;
            go = 1'b0; chan_mask = 4'd0; nsmp = '0; pretrig = '0;
        end
        data_ready = 1'b0; trig_addr = trig;
        repeat (2) @(posedge clk);
        #1 data_ready = 1'b1;
        for (k = 0; k < 8000; k++) begin
            @(negedge clk);
            if (done) break;
        end
        chk("done_seen", {31'd0, done}, 32'd1);
        chk("busy_at_done", {31'd0, busy}, 32'd0);
        repeat (3) @(negedge clk);
        chk("start_pulses", st_cnt, 1);
        chk("done_pulses", done_cnt, 1);
        chk("rd_left", exp_rd.size(), 0);
        chk("tx_left", exp_tx.size(), 0);
        chk("idle_tx_valid", {31'd0, tx_valid}, 32'd0);
        exp_rd.delete();
        exp_tx.delete();
    endtask

    initial begin
        int nrd;
        repeat (2) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
        chk("rst_rden", {31'd0, rden}, 32'd0);
        chk("rst_start", {31'd0, start_trigger}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        @(posedge clk); #1 rstn = 1'b1;

        run(4'b0001, 8, W'(3), W'(10), 1'b0);
        run(4'b0001, 4, W'(3), W'(1), 1'b1);
        run(4'b1010, 2, W'(0), W'(100), 1'b0);
        ready_mode = 1;
        run(4'b0101, 5, W'(2), W'(500), 1'b0);
        ready_mode = 0;

        // go with empty mask must not start anything
        st_cnt = 0;
        @(posedge clk); #1 chan_mask = 4'd0; go = 1'b1;
        @(posedge clk); #1 go = 1'b0;
        repeat (5) @(negedge clk);
        chk("mask0_start", st_cnt, 0);
        chk("mask0_busy", {31'd0, busy}, 32'd0);

        // abort mid-readout with reads in flight
        chk_en = 1'b0; ready_mode = 2; st_cnt = 0; done_cnt = 0; accepted = 0;
        @(posedge clk); #1 chan_mask = 4'b0001; nsmp = W'(8); pretrig = '0; go = 1'b1;
        @(posedge clk); #1 go = 1'b0; chan_mask = 4'd0; data_ready = 1'b0; trig_addr = W'(200);
        repeat (3) @(posedge clk);
        #1 data_ready = 1'b1;
        nrd = 0;
        for (int k = 0; k < 50 && nrd < 2; k++) begin
            @(negedge clk);
            if (rden) nrd++;
        end
        chk("abort_rd_seen", nrd, 2);
        @(posedge clk); #1 abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        @(negedge clk);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_tx_valid", {31'd0, tx_valid}, 32'd0);
        chk("abort_rden", {31'd0, rden}, 32'd0);
        ready_mode = 0;
        repeat (6) @(negedge clk);
        chk("abort_tx_after", {31'd0, tx_valid}, 32'd0);
        chk("abort_accepts", accepted, 0);
        chk("abort_no_done", done_cnt, 0);
        chk_en = 1'b1;

        run(4'b0001, 8, W'(3), W'(10), 1'b0);
        run(4'b0001, 0, W'(0), W'(0), 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
endmodule
